// File: rtl/fpu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fpu_pkg
// Purpose  : Shared FP32 definitions for the multiplier back end. Provides
//            special-value constants, exception flag bit positions, the
//            packed single-precision layout and the special-value resolver.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package fpu_pkg;

   localparam logic [31:0] QNAN    = 32'h7FC00000;
   localparam logic [7:0]  EXP_MAX = 8'hFF;

   // Bit positions inside a {invalid, overflow, zero} flag vector
   localparam int FLG_INV  = 2;
   localparam int FLG_OVF  = 1;
   localparam int FLG_ZERO = 0;

   typedef struct packed {
      logic        sign;
      logic [7:0]  exp;
      logic [22:0] man;
   } fp32_t;

   // Priority invalid > overflow > zero > pass-through. The NaN ignores the
   // product sign; infinity and zero keep it.
   function automatic logic [31:0] resolve_special(input fp32_t raw,
                                                   input logic [2:0] flags);
      logic [31:0] res;
      if (flags[FLG_INV])
         res = QNAN;
      else if (flags[FLG_OVF])
         res = {raw.sign, EXP_MAX, 23'h0};
      else if (flags[FLG_ZERO])
         res = {raw.sign, 31'h0};
      else
         res = raw;
      return res;
   endfunction

endpackage
`default_nettype wire

// File: rtl/mul_result_packer_if.sv
`default_nettype none
// ============================================================================
// Module   : mul_result_packer_if
// Purpose  : Bus bundle between the multiplier exception stage and the
//            result packer, plus the packer's valid/ready output side.
// Signals  : in_valid/in_sign/in_exp/in_man  raw result beat
//            invalid_flag/overflow_flag/initial_zero_flag  late flags
//            out_valid/out_ready/out_result/out_exc  output handshake
// Modports : master - producer/consumer side, slave - packer side
// Revision : 1.0 - initial release
// ============================================================================
interface mul_result_packer_if;

   logic        in_valid;
   logic        in_sign;
   logic [7:0]  in_exp;
   logic [22:0] in_man;
   logic        invalid_flag;
   logic        overflow_flag;
   logic        initial_zero_flag;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_result;
   logic [2:0]  out_exc;

   modport master (
      output in_valid, in_sign, in_exp, in_man,
      output invalid_flag, overflow_flag, initial_zero_flag,
      output out_ready,
      input  out_valid, out_result, out_exc
   );

   modport slave (
      input  in_valid, in_sign, in_exp, in_man,
      input  invalid_flag, overflow_flag, initial_zero_flag,
      input  out_ready,
      output out_valid, out_result, out_exc
   );

endinterface
`default_nettype wire

// File: rtl/result_fifo.sv
`default_nettype none
// ============================================================================
// Module   : result_fifo
// Purpose  : Small synchronous FIFO for packed results. Push is accepted
//            when not full, or when full with a simultaneous pop. rdata shows
//            the head entry and reads as zero while empty.
// Ports    : CLK, RST (async, active-low), push, pop, full, empty,
//            wdata[WIDTH-1:0], rdata[WIDTH-1:0]
// Revision : 1.0 - initial release
// ============================================================================
module result_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 35
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             push,
   input  logic             pop,
   output logic             full,
   output logic             empty,
   input  logic [WIDTH-1:0] wdata,
   output logic [WIDTH-1:0] rdata
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = PTR_W + 1;

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [PTR_W-1:0] r_wr_ptr;
   logic [PTR_W-1:0] r_rd_ptr;
   logic [CNT_W-1:0] r_count;

   logic w_do_pop;
   logic w_do_push;

   assign full      = (r_count == CNT_W'(DEPTH));
   assign empty     = (r_count == '0);
   assign w_do_pop  = pop && !empty;
   assign w_do_push = push && (!full || w_do_pop);
   assign rdata     = empty ? '0 : r_mem[r_rd_ptr];

   // Storage carries no reset; validity is tracked by the count alone.
   always_ff @(posedge CLK) begin
      if (w_do_push)
         r_mem[r_wr_ptr] <= wdata;
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_do_push)
            r_wr_ptr <= r_wr_ptr + PTR_W'(1);
         if (w_do_pop)
            r_rd_ptr <= r_rd_ptr + PTR_W'(1);
         case ({w_do_push, w_do_pop})
            2'b10:   r_count <= r_count + CNT_W'(1);
            2'b01:   r_count <= r_count - CNT_W'(1);
            default: r_count <= r_count;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: rtl/mul_result_packer.sv
`default_nettype none
// ============================================================================
// Module   : mul_result_packer
// Purpose  : FP multiplier back end. Delays the raw result beat so it lines
//            up with the late exception flags, substitutes IEEE-754 special
//            values, buffers results in a FIFO with valid/ready output and
//            accumulates sticky exception and drop status.
// Ports    : CLK, RST (async, active-low)
//            bus          (mul_result_packer_if.slave) beat, flags, output
//            sticky_clr   clears sticky_flags and drop_err
//            sticky_flags {invalid, overflow, zero}, OR-accumulated
//            drop_err     a beat was lost to a full FIFO
// Revision : 1.0 - initial release
// ============================================================================
module mul_result_packer
   import fpu_pkg::*;
#(
   parameter int FLAG_LAT = 1,
   parameter int DEPTH    = 4
) (
   input  logic                 CLK,
   input  logic                 RST,
   mul_result_packer_if.slave   bus,
   input  logic                 sticky_clr,
   output logic [2:0]           sticky_flags,
   output logic                 drop_err
);

   // ---------------------------------------------------------------------
   // Delay line: FLAG_LAT stages of {valid, beat}
   // ---------------------------------------------------------------------
   logic  r_dly_valid [FLAG_LAT];
   fp32_t r_dly_beat  [FLAG_LAT];

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         for (int k = 0; k < FLAG_LAT; k++) begin
            r_dly_valid[k] <= 1'b0;
            r_dly_beat[k]  <= '0;
         end
      end else begin
         r_dly_valid[0] <= bus.in_valid;
         r_dly_beat[0]  <= '{sign: bus.in_sign, exp: bus.in_exp, man: bus.in_man};
         for (int k = 1; k < FLAG_LAT; k++) begin
            r_dly_valid[k] <= r_dly_valid[k-1];
            r_dly_beat[k]  <= r_dly_beat[k-1];
         end
      end
   end

   // ---------------------------------------------------------------------
   // Resolve: the last delay stage meets the live (unregistered) flags
   // ---------------------------------------------------------------------
   logic        w_aligned_valid;
   fp32_t       w_aligned_beat;
   logic [2:0]  w_flags;
   logic [31:0] w_result;

   assign w_aligned_valid = r_dly_valid[FLAG_LAT-1];
   assign w_aligned_beat  = r_dly_beat[FLAG_LAT-1];

   always_comb begin
      w_flags           = '0;
      w_flags[FLG_INV]  = bus.invalid_flag;
      w_flags[FLG_OVF]  = bus.overflow_flag;
      w_flags[FLG_ZERO] = bus.initial_zero_flag;
   end

   assign w_result = resolve_special(w_aligned_beat, w_flags);

   // ---------------------------------------------------------------------
   // Output FIFO
   // ---------------------------------------------------------------------
   logic        w_full;
   logic        w_empty;
   logic        w_pop;
   logic        w_drop;
   logic [34:0] w_rdata;

   assign w_pop  = bus.out_valid && bus.out_ready;
   // A pop in the same cycle frees a slot, so only full-without-pop drops.
   assign w_drop = w_aligned_valid && w_full && !w_pop;

   result_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (35)
   ) u_fifo (
      .CLK   (CLK),
      .RST   (RST),
      .push  (w_aligned_valid),
      .pop   (w_pop),
      .full  (w_full),
      .empty (w_empty),
      .wdata ({w_flags, w_result}),
      .rdata (w_rdata)
   );

   assign bus.out_valid  = !w_empty;
   assign bus.out_exc    = w_rdata[34:32];
   assign bus.out_result = w_rdata[31:0];

   // ---------------------------------------------------------------------
   // Sticky status: new events are OR-ed in after the clear, so a push or
   // drop in the clear cycle still leaves its bits set.
   // ---------------------------------------------------------------------
   logic [2:0] r_sticky;
   logic       r_drop_err;

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         r_sticky   <= 3'b000;
         r_drop_err <= 1'b0;
      end else begin
         r_sticky   <= (sticky_clr ? 3'b000 : r_sticky)
                     | (w_aligned_valid ? w_flags : 3'b000);
         r_drop_err <= (sticky_clr ? 1'b0 : r_drop_err) | w_drop;
      end
   end

   assign sticky_flags = r_sticky;
   assign drop_err     = r_drop_err;

endmodule
`default_nettype wire

// File: doc/mul_result_packer.md
# mul_result_packer

Back end of the FP multiplier pipeline, at the output of the multiplier's exception-flag generator. It aligns the late-arriving exception flags with the delayed raw sign/exponent/mantissa and substitutes IEEE-754 single-precision special values where a flag is set. Results are buffered in a small FIFO and presented on a valid/ready handshake. IEEE-style sticky status flags and a buffer-drop error are accumulated.

## Interface
- FLAG_LAT, 1: cycles by which exception flags trail their data beat (1..4).
- DEPTH, 4: output FIFO entries, power of two, ≥2.
- CLK  in  1  clock
- RST  in  1  reset, asynchronous, active-low
- in_valid  in  1  raw result beat valid; no input backpressure
- in_sign  in  1  product sign
- in_exp  in  8  biased exponent
- in_man  in  23  fraction
- invalid_flag  in  1  valid FLAG_LAT cycles after the matching in_valid
- overflow_flag  in  1  same alignment
- initial_zero_flag  in  1  same alignment
- out_valid  out  1  FIFO head valid
- out_ready  in  1  consumer accepts
- out_result  out  32  packed IEEE-754 word
- out_exc  out  3  {invalid, overflow, zero} as applied to this word
- sticky_flags  out  3  {invalid, overflow, zero}, OR-accumulated
- sticky_clr  in  1  clears sticky_flags and drop_err
- drop_err  out  1  sticky: a beat was lost to a full FIFO

## Operation
- Delay line: FLAG_LAT register stages carry {in_valid, in_sign, in_exp, in_man}. The stage-FLAG_LAT output is paired with the current flags; the flags are not registered.
- Resolve, priority invalid > overflow > zero > normal:
  - invalid → 32'h7FC00000 (sign ignored).
  - overflow → {sign, 8'hFF, 23'h0}.
  - zero → {sign, 31'h0}.
  - else → {sign, exp, man}.
- out_exc carries all three raw flags, not only the winning one.
- Push: a resolved beat with aligned valid=1 is written to the FIFO in that cycle.
- Pop: occurs when out_valid && out_ready.
- Full, push, no pop: the beat is dropped, drop_err is set, and FIFO contents are unchanged.
- Full, push, simultaneous pop: the push is accepted and the count is unchanged.
- Empty, push, out_ready=1: no bypass. The beat appears on the next cycle.
- Sticky flags: on every accepted or dropped push, sticky_flags |= raw flags.
- Sticky clear: sticky_clr zeroes sticky_flags and drop_err. A same-cycle push's flags, or a same-cycle drop, still set their bits, so set wins over clear for new events.
- Flags present when the aligned valid=0 are ignored.

## Timing
- Reset values: out_valid=0, out_result=0, out_exc=0, sticky_flags=0, drop_err=0. Reset also clears the delay line and the FIFO pointers and count.
- Latency: in_valid at cycle t, flags at t+FLAG_LAT, out_valid at t+FLAG_LAT+1 when the FIFO was empty.
- Throughput: one beat per cycle while out_ready=1.
- Hold: out_result and out_exc stay stable while out_valid=1 && out_ready=0.
- Reset mid-operation (async assert): all in-flight and buffered beats are discarded immediately. No output is produced for beats whose flags arrive after reset release.
- FIFO pointers wrap modulo DEPTH. The count is log2(DEPTH)+1 bits wide, so full and empty are distinguishable.
- Dropping a beat at full never stalls, corrupts, or reorders the queued beats.

## Structure
- Shared package fpu_pkg holds:
  - QNAN = 32'h7FC00000, EXP_MAX = 8'hFF.
  - Flag bit indices: FLG_INV=2, FLG_OVF=1, FLG_ZERO=0.
  - typedef fp32_t {sign, exp[7:0], man[22:0]}.
- Sub-module result_fifo, parameterized by DEPTH and width 35 ({exc, result}):
  - Ports: push, pop, full, empty, wdata, rdata.
- The delay line, resolve logic and sticky logic live in the top module.

## Test plan
- Normal beat:
  - Stimulus: FLAG_LAT=1, in {0, 8'h80, 23'h1}, flags 0, out_ready=1.
  - Required: out_result=32'h40000001 with out_exc=0, two cycles after in_valid.
- Simultaneous flags:
  - Stimulus: invalid=1 and overflow=1 on a beat with sign=1.
  - Required: out_result=32'h7FC00000, out_exc=3'b110, sticky_flags=3'b110.
- Overflow and zero:
  - Stimulus: overflow on a sign=1 beat, then zero on a sign=1 beat.
  - Required: 32'hFF800000, then 32'h80000000.
- Backpressure and drop:
  - Stimulus: out_ready=0, 5 back-to-back beats, DEPTH=4.
  - Required: beats 1–4 queued, beat 5 dropped, drop_err=1.
  - Then with out_ready=1: beats 1–4 emerge in order, with no gap.
- Sticky set vs. clear:
  - Stimulus: sticky_clr in the same cycle as a zero-flagged push.
  - Required: sticky_flags=3'b001 afterwards.
- Reset mid-operation:
  - Stimulus: assert RST with 3 beats queued and 1 in the delay line.
  - Required: out_valid=0 immediately, no spurious output after release.
